// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one byte per frame and serializes it LSB first.
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    parity_bit;
`endif

    logic baud_done;
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            tx           <= 1'b1;
            fifo_read_en <= 1'b0;
            busy         <= 1'b0;
            byte_done    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            byte_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        fifo_read_en <= 1'b1;
                        busy         <= 1'b1;
                        state        <= REQ;
                    end
                end

                REQ: begin
                    fifo_read_en <= 1'b0;
                    state        <= LOAD;
                end

                LOAD: begin
                    shift_reg <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_bit <= ^fifo_data;
`endif
                    tx        <= 1'b0;
                    baud_cnt  <= '0;
                    state     <= START;
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            tx      <= parity_bit;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            // tx takes the next bit directly so it lines up with the shift
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt   <= '0;
                            byte_done <= 1'b1;
                            if (enable && !fifo_empty) begin
                                fifo_read_en <= 1'b1;
                                state        <= REQ;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO feeding the DUT, frames decoded
// against bit lists built from each pushed byte.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
    localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = 1 + DW + P + SB;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    bit         rand_mode = 1'b1;
    logic       rand_empty = 1'b0;
    logic [7:0] rand_data = 8'h00;
    logic [7:0] q_data;
    logic [7:0] mem [0:127];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    int         rd_en_cycles = 0;
    bit         bad_pop = 1'b0;
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign fifo_empty = rand_mode ? rand_empty : (wr_ptr == rd_ptr);
    assign fifo_data  = rand_mode ? rand_data  : q_data;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_WIDTH   (DW),
        .STOP_BITS    (SB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .tx           (tx),
        .busy         (busy),
        .byte_done    (byte_done)
    );

    // Behavioural FIFO: pops on a clock edge where read_en is high; data registered.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read_en) rd_en_cycles <= rd_en_cycles + 1;
        if (fifo_read_en && fifo_empty) begin
            bad_pop <= 1'b1;
        end else if (fifo_read_en) begin
            q_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Waits for a start bit, then checks every clock of the frame against the byte's bit list.
    task automatic check_frame(input logic [7:0] b, input int max_wait, output int t_start);
        logic fb [0:15];
        bit   seen;
        logic got_bit;
        int   bad_ctl;
        fb[0] = 1'b0;
        for (int i = 0; i < DW; i++) fb[1+i] = b[i];
        if (P == 1) fb[1+DW] = ^b;
        for (int s = 0; s < SB; s++) fb[1+DW+P+s] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        t_start = cyc;
        check("start_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        bad_ctl = 0;
        for (int k = 0; k < FRAME; k++) begin
            got_bit = fb[k];
            for (int c = 0; c < CPB; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (tx !== fb[k]) got_bit = tx;
                if (busy !== 1'b1 || byte_done !== 1'b0 || fifo_read_en !== 1'b0) bad_ctl++;
            end
            check($sformatf("frame_%02h_bit%0d", b, k), {31'd0, got_bit}, {31'd0, fb[k]});
        end
        check("frame_ctl_bad_cycles", bad_ctl, 0);
        @(negedge clk);
        check("byte_done_pulse", {31'd0, byte_done}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t1, t2, t0, base, bad, n;
        logic [7:0] x, y;

        // Reset held with random inputs
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            enable     = 1'($urandom_range(0, 1));
            rand_empty = 1'($urandom_range(0, 1));
            rand_data  = 8'($urandom_range(0, 255));
            #1;
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_read_en", {31'd0, fifo_read_en}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_byte_done", {31'd0, byte_done}, 32'd0);
        end
        @(negedge clk);
        rand_mode = 1'b0;
        enable    = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
        base = rd_en_cycles;
        push(8'hA5);
        enable = 1'b1;
        check_frame(exp_q.pop_front(), 10, t1);
        check("single_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("single_done_once", {31'd0, byte_done}, 32'd0);
        repeat (20) @(negedge clk);
        check("single_pop_count", rd_en_cycles - base, 1);
        check("single_idle_tx", {31'd0, tx}, 32'd1);

        // Back-to-back 0x00, 0xFF
        base = rd_en_cycles;
        push(8'h00);
        push(8'hFF);
        check_frame(exp_q.pop_front(), 10, t1);
        check_frame(exp_q.pop_front(), 10, t2);
        check("b2b_spacing", t2 - t1, FRAME * CPB + 2);
        repeat (5) @(negedge clk);
        check("b2b_pop_count", rd_en_cycles - base, 2);
        check("b2b_fifo_empty", {31'd0, fifo_empty}, 32'd1);
        check("b2b_busy_low", {31'd0, busy}, 32'd0);

        // Gating: enable low with data waiting
        enable = 1'b0;
        push(8'($urandom_range(0, 255)));
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_read_en !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("gate_idle_bad_cycles", bad, 0);
        t0 = cyc;
        enable = 1'b1;
        check_frame(exp_q.pop_front(), 10, t1);
        // request sampled on the next edge, tx falls two edges after that
        check("gate_start_latency", t1 - t0, 3);

        // enable dropped mid-frame: frame completes, no further fetch
        repeat (3) @(negedge clk);
        base = rd_en_cycles;
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        fork
            check_frame(exp_q.pop_front(), 10, t1);
            begin
                repeat (20) @(negedge clk);
                enable = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("middrop_pop_count", rd_en_cycles - base, 1);
        check("middrop_busy", {31'd0, busy}, 32'd0);
        check("middrop_fifo_left", {31'd0, fifo_empty}, 32'd0);
        enable = 1'b1;
        check_frame(exp_q.pop_front(), 10, t1);

        // Abort during data bit 3
        repeat (3) @(negedge clk);
        x = 8'($urandom_range(0, 255)) & 8'hF7;
        y = 8'($urandom_range(0, 255));
        push(x);
        push(y);
        bad = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                bad = 0;
                break;
            end
        end
        check("abort_start_seen", bad, 0);
        repeat (17) @(negedge clk);
        check("abort_pre_bit3", {31'd0, tx}, {31'd0, x[3]});
        #1 reset = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_read_en", {31'd0, fifo_read_en}, 32'd0);
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_frame(exp_q.pop_front(), 10, t1);

        // Random bursts
        for (int r = 0; r < 4; r++) begin
            repeat (int'($urandom_range(2, 8))) @(negedge clk);
            n = int'($urandom_range(1, 5));
            for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
            t2 = 0;
            for (int j = 0; j < n; j++) begin
                check_frame(exp_q.pop_front(), 10, t1);
                if (j > 0) check($sformatf("rand%0d_spacing", r), t1 - t2, FRAME * CPB + 2);
                t2 = t1;
            end
            repeat (3) @(negedge clk);
            check($sformatf("rand%0d_busy", r), {31'd0, busy}, 32'd0);
            check($sformatf("rand%0d_empty", r), {31'd0, fifo_empty}, 32'd1);
        end

`ifdef FIFO_UART_TX_PARITY_EN
        repeat (3) @(negedge clk);
        push(8'h07);
        push(8'h03);
        check_frame(exp_q.pop_front(), 10, t1);
        check_frame(exp_q.pop_front(), 10, t2);
        check("parity_spacing", t2 - t1, 46);
`endif

        repeat (3) @(negedge clk);
        check("no_pop_when_empty", {31'd0, bad_pop}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
